pwm_symbol_encoder: RTL and testbench

Transmit-side counterpart of decoder_top. Converts a stream of 8-bit symbols into a 16-bit signed baseband sample stream using pulse-width encoding: each symbol becomes a HIGH_LEVEL pulse whose length encodes the value, followed by a fixed LOW_LEVEL gap. The output feeds the SDR TX sample path. In loopback, it drives decoder_top's data_in directly, with the decoder's ref_in set between LOW_LEVEL and HIGH_LEVEL.

---
 rtl/pwm_symbol_encoder_if.sv | 19 +
 rtl/pwm_symbol_encoder.sv | 94 +++++++++
 tb/tb_pwm_symbol_encoder.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_symbol_encoder_if.sv
// Symbol handshake between a symbol source and the pulse-width encoder.
// The source presents symbol_in/symbol_valid and the encoder answers with symbol_ready.
interface pwm_symbol_encoder_if;
    logic [7:0] symbol_in;
    logic       symbol_valid;
    logic       symbol_ready;

    modport master (
        output symbol_in,
        output symbol_valid,
        input  symbol_ready
    );

    modport slave (
        input  symbol_in,
        input  symbol_valid,
        output symbol_ready
    );
endinterface

// File: rtl/pwm_symbol_encoder.sv
// Pulse-width symbol encoder: each 8-bit symbol becomes symbol+1 HIGH_LEVEL samples
// followed by GAP_LEN LOW_LEVEL samples, advancing only on enable strobes.
module pwm_symbol_encoder #(
    parameter int unsigned                DATA_W     = 16,
    parameter logic signed [DATA_W-1:0]   HIGH_LEVEL = 16'sd1000,
    parameter logic signed [DATA_W-1:0]   LOW_LEVEL  = 16'sd0,
    parameter int unsigned                GAP_LEN    = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     enable,
    pwm_symbol_encoder_if.slave      sym,
    output logic signed [DATA_W-1:0] data_out,
    output logic                     busy,
    output logic                     sym_done,
    output logic [15:0]              symbol_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] pulse_cnt;
    logic [7:0] gap_cnt;
    logic       accept;

    // Ready on the last gap sample too, so a waiting symbol follows with no idle bubble.
    assign sym.symbol_ready = reset_n & enable &
                              ((state == IDLE) | ((state == GAP) & (gap_cnt == 8'd0)));
    assign accept = sym.symbol_valid & sym.symbol_ready;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            pulse_cnt    <= 8'd0;
            gap_cnt      <= 8'd0;
            data_out     <= LOW_LEVEL;
            busy         <= 1'b0;
            sym_done     <= 1'b0;
            symbol_count <= 16'd0;
        end else begin
            sym_done <= 1'b0;
            if (enable) begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            state     <= PULSE;
                            pulse_cnt <= sym.symbol_in;
                            data_out  <= HIGH_LEVEL;
                            busy      <= 1'b1;
                        end else begin
                            data_out  <= LOW_LEVEL;
                        end
                    end
                    PULSE: begin
                        // pulse_cnt counts down from the symbol, giving symbol+1 high samples.
                        if (pulse_cnt == 8'd0) begin
                            state    <= GAP;
                            gap_cnt  <= 8'(GAP_LEN - 1);
                            data_out <= LOW_LEVEL;
                        end else begin
                            pulse_cnt <= pulse_cnt - 8'd1;
                        end
                    end
                    GAP: begin
                        if (gap_cnt == 8'd0) begin
                            sym_done     <= 1'b1;
                            symbol_count <= symbol_count + 16'd1;
                            if (accept) begin
                                state     <= PULSE;
                                pulse_cnt <= sym.symbol_in;
                                data_out  <= HIGH_LEVEL;
                            end else begin
                                state     <= IDLE;
                                busy      <= 1'b0;
                            end
                        end else begin
                            gap_cnt <= gap_cnt - 8'd1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        data_out <= LOW_LEVEL;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_symbol_encoder.sv
// Bench for pwm_symbol_encoder: position-based reference model checked every cycle,
// plus literal expectations for the directed scenarios and a simple loopback decoder.
module tb_pwm_symbol_encoder;

    localparam int GAP = 4;
    localparam int HI  = 1000;
    localparam int REF = 30;

    logic               clock;
    logic               reset_n;
    logic               enable;
    logic signed [15:0] data_out;
    logic               busy;
    logic               sym_done;
    logic [15:0]        symbol_count;

    pwm_symbol_encoder_if sif ();

    pwm_symbol_encoder #(
        .DATA_W    (16),
        .HIGH_LEVEL(16'sd1000),
        .LOW_LEVEL (16'sd0),
        .GAP_LEN   (GAP)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .sym         (sif),
        .data_out    (data_out),
        .busy        (busy),
        .sym_done    (sym_done),
        .symbol_count(symbol_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Model: a symbol occupies positions 0..sym+GAP after its accept edge;
    // positions 0..sym are high, the rest are the gap.
    bit m_act  = 0;
    int m_sym  = 0;
    int m_pos  = 0;
    int m_cnt  = 0;
    bit m_done = 0;
    bit m_acc  = 0;
    bit chk_en = 0;

    function automatic bit m_ready();
        return reset_n && enable && (!m_act || (m_pos == m_sym + GAP));
    endfunction

    task automatic cyc();
        bit acc;
        int sv;
        acc = sif.symbol_valid && m_ready();
        sv  = int'(sif.symbol_in);
        @(posedge clock);
        #1;
        m_acc = 0;
        if (!reset_n) begin
            m_act = 0; m_cnt = 0; m_done = 0; m_pos = 0;
        end else if (enable) begin
            m_done = 0;
            if (m_act && m_pos == m_sym + GAP) begin
                m_done = 1;
                m_cnt  = (m_cnt + 1) % 65536;
                m_act  = 0;
            end
            if (acc) begin
                m_act = 1; m_sym = sv; m_pos = 0; m_acc = 1;
            end else if (m_act) begin
                m_pos++;
            end
        end else begin
            m_done = 0;
        end
        chk_en = 1;
    endtask

    // Per-cycle comparison and observation counters.
    int hi_cnt   = 0;
    int done_cnt = 0;
    int rdy_dis  = 0;
    int run_len  = 0;
    int dq[$];

    always @(negedge clock) begin
        if (chk_en) begin
            chk("data_out", data_out, (m_act && m_pos <= m_sym) ? HI : 0);
            chk("busy", busy, m_act);
            chk("sym_done", sym_done, m_done);
            chk("symbol_count", symbol_count, m_cnt);
            chk("symbol_ready", sif.symbol_ready, m_ready());
            if (data_out == 16'sd1000) hi_cnt++;
            if (sym_done) done_cnt++;
            if (sif.symbol_ready && !enable) rdy_dis++;
            if (data_out > REF) run_len++;
            else if (run_len > 0) begin
                dq.push_back(run_len - 1);
                run_len = 0;
            end
        end
    end

    task automatic send(input int s, input string nm);
        int n = 0;
        sif.symbol_valid = 1'b1;
        sif.symbol_in    = 8'(s);
        while (n < 600) begin
            cyc();
            n++;
            if (m_acc) break;
        end
        if (!m_acc) chk({nm, "_accept_timeout"}, 0, 1);
        sif.symbol_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (m_act && n < 1200) begin
            cyc();
            n++;
        end
        if (m_act) chk({nm, "_idle_timeout"}, 0, 1);
    endtask

    int b_hi, b_done, b_rdy, b_dq, n;

    initial begin
        reset_n          = 1'b0;
        enable           = 1'b1;
        sif.symbol_valid = 1'b0;
        sif.symbol_in    = 8'd0;

        // 1: reset then idle
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t1_rst_ready", sif.symbol_ready, 0);
            chk("t1_rst_data", data_out, 0);
            chk("t1_rst_busy", busy, 0);
        end
        reset_n = 1'b1;
        #1;
        chk("t1_ready_after", sif.symbol_ready, 1);
        cyc();
        chk("t1_count", symbol_count, 0);

        // 2: single symbol 5
        b_hi = hi_cnt; b_done = done_cnt;
        send(5, "t2");
        chk("t2_first_high", data_out, HI);
        n = 0;
        while (n < 50) begin
            cyc();
            n++;
            if (sym_done) break;
        end
        chk("t2_cycles_to_done", n, 10);
        chk("t2_count", symbol_count, 1);
        cyc();
        chk("t2_busy_idle", busy, 0);
        chk("t2_high_samples", hi_cnt - b_hi, 6);
        chk("t2_done_pulses", done_cnt - b_done, 1);

        // 3: back-to-back 0 then 255
        b_hi = hi_cnt; b_done = done_cnt;
        send(0, "t3a");
        sif.symbol_valid = 1'b1;
        sif.symbol_in    = 8'd255;
        n = 0;
        while (n < 50) begin
            cyc();
            n++;
            if (m_acc) break;
        end
        sif.symbol_valid = 1'b0;
        chk("t3_gap_to_next", n, 5);
        wait_idle("t3");
        cyc();
        chk("t3_high_samples", hi_cnt - b_hi, 257);
        chk("t3_done_pulses", done_cnt - b_done, 2);
        chk("t3_count", symbol_count, 3);

        // 4: enable gating, symbol 3
        b_hi = hi_cnt; b_done = done_cnt; b_rdy = rdy_dis;
        send(3, "t4");
        n = 0;
        while (m_act && n < 100) begin
            enable = ~enable;
            cyc();
            n++;
        end
        enable = 1'b1;
        cyc();
        chk("t4_high_clocks", hi_cnt - b_hi, 8);
        chk("t4_total_clocks", n, 16);
        chk("t4_ready_disabled", rdy_dis - b_rdy, 0);
        chk("t4_done_pulses", done_cnt - b_done, 1);

        // 5: reset mid-pulse on symbol 10
        b_done = done_cnt;
        send(10, "t5");
        cyc();
        cyc();
        chk("t5_high_before", data_out, HI);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        chk("t5_data", data_out, 0);
        chk("t5_busy", busy, 0);
        chk("t5_count", symbol_count, 0);
        cyc();
        cyc();
        chk("t5_no_done", done_cnt - b_done, 0);

        // 6: loopback into a threshold decoder
        b_dq = dq.size();
        send(7, "t6a");
        send(42, "t6b");
        send(200, "t6c");
        wait_idle("t6");
        cyc();
        cyc();
        chk("t6_decoded_n", dq.size() - b_dq, 3);
        if (dq.size() >= b_dq + 3) begin
            chk("t6_sym0", dq[b_dq], 7);
            chk("t6_sym1", dq[b_dq + 1], 42);
            chk("t6_sym2", dq[b_dq + 2], 200);
        end
        chk("t6_count", symbol_count, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
